data_mem_unit: RTL and testbench
================================

# data_mem_unit

Data-side memory subsystem directly downstream of the single-cycle MIPS core's data port. It consumes `mem_read`, `mem_write`, `data_addr` and `data_out` from the core and returns `data_in` in the same cycle. It holds word-addressed data RAM plus a small memory-mapped I/O page: a console TX FIFO drained over a valid/ready handshake, a status register and an optional cycle counter.

## Interface

- `DEPTH`, 1024: data RAM size in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, 2..128.
- `MMIO_BASE`, 32'hFFFF_0000: byte base of the MMIO page.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  core read enable.
- `mem_write`  in  1  core write enable.
- `data_addr`  in  32  core byte address.
- `proc_wdata`  in  32  store data from the core's `data_out`.
- `proc_rdata`  out  32  load data to the core's `data_in`; combinational.
- `con_data`  out  8  FIFO head byte.
- `con_valid`  out  1  FIFO non-empty.
- `con_ready`  in  1  console sink accepts the head byte.
- `addr_err`  out  1  sticky bad-access flag.

## Operation

- **Address decode:**
  - RAM when `data_addr < DEPTH*4`; word index is `data_addr[log2(DEPTH)+1:2]`.
  - MMIO registers:
    - TXDATA at `MMIO_BASE+0`: write pushes `proc_wdata[7:0]`; reads return 0.
    - STATUS at `MMIO_BASE+4`: bits [0] empty, [1] full, [2] overflow, [15:8] count (zero-extended); other bits 0.
    - CYCLES at `MMIO_BASE+8`: only with the macro.
- **Bad access:**
  - Triggered by a misaligned address (`data_addr[1:0]≠0`) or an unmapped address with `mem_read` or `mem_write` high.
  - Write ignored, read returns 0, `addr_err` set at the next edge; it stays set until `rst`.
- **Reads:**
  - `proc_rdata` is valid in the same cycle as `mem_read`.
  - `proc_rdata` = 0 whenever `mem_read`=0.
- **Writes:**
  - RAM write at the rising edge with `mem_write`.
  - With `mem_read` and `mem_write` both high, the read returns the pre-write value.
- **FIFO:**
  - A push is accepted if not full, or if a pop occurs in the same cycle (count unchanged).
  - A push to a full FIFO with no pop is dropped and sets overflow (sticky). Any write to STATUS clears overflow.
  - Pop when `con_valid && con_ready`. Bytes leave in write order.
  - `con_data` = 0 while empty.
- **RAM contents:** not cleared by `rst`. Benches preload with `$readmemh` on the array.

## Timing

- **Reset values:**
  - `con_valid`=0, `con_data`=0, `addr_err`=0.
  - FIFO pointers, count and overflow are 0; CYCLES is 0.
  - `proc_rdata` is combinational, so it is 0 while `mem_read`=0.
- **Latency:**
  - Load data arrives in 0 cycles.
  - A store is visible to a load in the following cycle.
  - TXDATA write to `con_valid`=1 takes 1 cycle. A push into an empty FIFO cannot pop in the same cycle.
- **Handshake:**
  - `con_valid` never drops without a pop.
  - `con_data` is stable while `con_valid && !con_ready`.
- **STATUS read timing:** STATUS reflects the state before the current edge. A same-cycle push is not counted yet.
- **Pointers:** wrap modulo `FIFO_DEPTH`. The count range is 0..`FIFO_DEPTH`.
- **Reset mid-transfer:** `rst` during a pending handshake empties the FIFO at that edge. The byte is lost and `con_valid`=0 next cycle.

## Configuration

- `DMEM_CYCLE_COUNTER_EN` defined:
  - 32-bit CYCLES register increments every cycle after reset and wraps at 2^32-1 → 0.
  - A write to CYCLES loads 0 at that edge, and counting resumes the next cycle.
  - Reads return the current value.
- Not defined:
  - No counter logic.
  - `MMIO_BASE+8` is unmapped: reads return 0, and `addr_err` sets on access.

## Structure

- **Shared package `dmem_pkg`:**
  - MMIO offsets (`TXDATA_OFS`, `STATUS_OFS`, `CYCLES_OFS`).
  - STATUS bit positions.
  - `WORD_WIDTH`=32.
- **Sub-module `dmem_tx_fifo`:**
  - Parameterised sync FIFO with push, pop, full, empty, count and overflow.
  - It is the only sub-module; the top level holds the RAM array, address decode, read mux and the counter.

## Test plan

- **Store/load:** write 32'hDEADBEEF at 0x10, then read 0x10 the next cycle → `proc_rdata`=32'hDEADBEEF. Read with `mem_read`=0 → 0.
- **Console drain:** push 'H','i' with `con_ready`=0 → STATUS=0x0000_0200. Raise `con_ready` → 'H' then 'i' on consecutive cycles, then `con_valid`=0 and STATUS=0x1.
- **Overflow and full-push:** push 9 bytes with `FIFO_DEPTH`=8 and `con_ready`=0 → STATUS=0x0000_0806 and the 9th byte is dropped. Write STATUS → bit 2 clears. On a full FIFO, push with `con_ready`=1 → push accepted and count stays 8.
- **Bad accesses:** read 0x13 → 0 and `addr_err`=1 next cycle. Write to 0x8000_0000 → no RAM change. Assert `rst` → `addr_err`=0.
- **Cycle counter (macro on):** read CYCLES 5 cycles after reset → 5. Write CYCLES, then read 1 cycle later → 1. Force 32'hFFFF_FFFF → wraps to 0.
- **Reset mid-transfer:** 3 bytes queued, `con_ready`=0, assert `rst` → `con_valid`=0 next cycle, STATUS=0x1, and RAM contents unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory subsystem: MMIO offsets, STATUS layout, decode regions.
package dmem_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] CYCLES_OFS = 32'h0000_0008;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_TXDATA,
        RGN_STATUS,
        RGN_CYCLES
    } dmem_region_e;

    function automatic logic [WORD_WIDTH-1:0] status_word(input logic empty, input logic full,
                                                          input logic ovf, input logic [7:0] count);
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[STAT_EMPTY_BIT] = empty;
        w[STAT_FULL_BIT]  = full;
        w[STAT_OVF_BIT]   = ovf;
        w[STAT_COUNT_LSB +: 8] = count;
        return w;
    endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// Synchronous console TX FIFO; a push into a full FIFO is accepted only when a pop frees a slot
// in the same cycle, otherwise it is dropped and the sticky overflow flag is raised.
module dmem_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clr_ovf,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_empty,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_buf [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             w_pop;
    logic             w_push;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_rdata    = o_empty ? '0 : r_buf[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            if (i_clr_ovf)
                r_overflow <= 1'b0;
            else if (i_push && !w_push)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/data_mem_unit.sv
// Data RAM plus MMIO page (console TX FIFO, STATUS, optional CYCLES) behind the core's data port.
// Optional cycle counter enabled by defining DMEM_CYCLE_COUNTER_EN.
module data_mem_unit
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] proc_wdata,
    output logic [31:0] proc_rdata,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        addr_err
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_addr_err;
    dmem_region_e          w_region;
    logic [AW-1:0]         w_word_idx;
    logic                  w_bad;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_ovf;
    logic [CW-1:0]         w_count;
    logic [WORD_WIDTH-1:0] w_status;

    assign w_word_idx = data_addr[AW+1:2];

    // Misaligned addresses never match any region, so they fall through to RGN_NONE.
    always_comb begin
        w_region = RGN_NONE;
        if (data_addr[1:0] == 2'b00) begin
            if (data_addr < RAM_BYTES)
                w_region = RGN_RAM;
            else if (data_addr == MMIO_BASE + TXDATA_OFS)
                w_region = RGN_TXDATA;
            else if (data_addr == MMIO_BASE + STATUS_OFS)
                w_region = RGN_STATUS;
`ifdef DMEM_CYCLE_COUNTER_EN
            else if (data_addr == MMIO_BASE + CYCLES_OFS)
                w_region = RGN_CYCLES;
`endif
        end
    end

    assign w_bad = (mem_read || mem_write) && (w_region == RGN_NONE);

    always_ff @(posedge clk) begin
        if (rst) r_addr_err <= 1'b0;
        else if (w_bad) r_addr_err <= 1'b1;
    end
    assign addr_err = r_addr_err;

    always_ff @(posedge clk) begin
        if (mem_write && w_region == RGN_RAM) r_mem[w_word_idx] <= proc_wdata;
    end

    dmem_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (mem_write && w_region == RGN_TXDATA),
        .i_pop     (con_ready),
        .i_clr_ovf (mem_write && w_region == RGN_STATUS),
        .i_wdata   (proc_wdata[7:0]),
        .o_rdata   (con_data),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_overflow(w_ovf),
        .o_count   (w_count)
    );

    assign con_valid = !w_empty;
    assign w_status  = status_word(w_empty, w_full, w_ovf, 8'(w_count));

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk) begin
        if (rst)
            r_cycles <= '0;
        else if (mem_write && w_region == RGN_CYCLES)
            r_cycles <= '0;
        else
            r_cycles <= r_cycles + 32'd1;
    end
`endif

    // RAM reads are asynchronous so a simultaneous write still returns the old word.
    always_comb begin
        proc_rdata = '0;
        if (mem_read) begin
            case (w_region)
                RGN_RAM:    proc_rdata = r_mem[w_word_idx];
                RGN_STATUS: proc_rdata = w_status;
`ifdef DMEM_CYCLE_COUNTER_EN
                RGN_CYCLES: proc_rdata = r_cycles;
`endif
                default:    proc_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: RAM store/load, console FIFO, overflow, bad accesses, reset.
module tb_data_mem_unit;

    localparam logic [31:0] TX_A  = 32'hFFFF_0000;
    localparam logic [31:0] ST_A  = 32'hFFFF_0004;
    localparam logic [31:0] CYC_A = 32'hFFFF_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_addr;
    logic [31:0] proc_wdata;
    logic [31:0] proc_rdata;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    data_mem_unit #(
        .DEPTH(1024),
        .FIFO_DEPTH(8),
        .MMIO_BASE(32'hFFFF_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_addr (data_addr),
        .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata),
        .con_data  (con_data),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        data_addr  = a;
        proc_wdata = d;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        data_addr = a;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        #1;
        chk(tag, proc_rdata, exp);
        tick();
        mem_read  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        data_addr  = '0;
        proc_wdata = '0;
        con_ready  = 1'b0;
        tick();
        tick();
        chk("rst_con_valid", {31'b0, con_valid}, 32'd0);
        chk("rst_con_data", {24'b0, con_data}, 32'd0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
        chk("rst_rdata", proc_rdata, 32'd0);
        rst = 1'b0;
        tick();
        rd("rst_status", ST_A, 32'h0000_0001);

        // Store / load, read-before-write, read disabled
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("load_10", 32'h0000_0010, 32'hDEAD_BEEF);
        data_addr = 32'h0000_0010;
        #1;
        chk("read_disabled", proc_rdata, 32'd0);
        wr(32'h0000_0FFC, 32'hA5A5_5A5A);
        rd("load_top", 32'h0000_0FFC, 32'hA5A5_5A5A);
        data_addr  = 32'h0000_0010;
        proc_wdata = 32'h1234_5678;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        #1;
        chk("rw_old_value", proc_rdata, 32'hDEAD_BEEF);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rd("rw_new_value", 32'h0000_0010, 32'h1234_5678);
        rd("load_0", 32'h0000_0000, 32'h1111_1111);
        chk("no_err_yet", {31'b0, addr_err}, 32'd0);

        // Console drain
        wr(TX_A, 32'h0000_0048);
        chk("push1_valid", {31'b0, con_valid}, 32'd1);
        chk("push1_data", {24'b0, con_data}, 32'h48);
        wr(TX_A, 32'h0000_0069);
        rd("status_two", ST_A, 32'h0000_0200);
        chk("hold_data", {24'b0, con_data}, 32'h48);
        con_ready = 1'b1;
        tick();
        chk("drain_i", {24'b0, con_data}, 32'h69);
        chk("drain_i_valid", {31'b0, con_valid}, 32'd1);
        tick();
        chk("drain_done_valid", {31'b0, con_valid}, 32'd0);
        chk("drain_done_data", {24'b0, con_data}, 32'd0);
        con_ready = 1'b0;
        rd("status_empty", ST_A, 32'h0000_0001);
        rd("txdata_reads_0", TX_A, 32'd0);

        // Overflow, clear, full push with simultaneous pop
        for (int i = 0; i < 9; i++) wr(TX_A, 32'h30 + 32'(i));
        rd("status_ovf", ST_A, 32'h0000_0806);
        chk("ovf_head", {24'b0, con_data}, 32'h30);
        wr(ST_A, 32'd0);
        rd("status_ovf_clr", ST_A, 32'h0000_0802);
        con_ready = 1'b1;
        wr(TX_A, 32'h0000_0039);
        con_ready = 1'b0;
        rd("status_full_pushpop", ST_A, 32'h0000_0802);
        chk("fullpush_head", {24'b0, con_data}, 32'h31);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'b0, con_valid}, 32'd1);
            chk("drain_order", {24'b0, con_data}, (i < 7) ? 32'h31 + 32'(i) : 32'h39);
            tick();
        end
        chk("drain8_empty", {31'b0, con_valid}, 32'd0);
        con_ready = 1'b0;

        // Bad accesses
        rd("ram_end_unmapped", 32'h0000_1000, 32'd0);
        chk("err_ram_end", {31'b0, addr_err}, 32'd1);
        do_reset();
        chk("err_cleared1", {31'b0, addr_err}, 32'd0);
        rd("misaligned", 32'h0000_0013, 32'd0);
        chk("err_misaligned", {31'b0, addr_err}, 32'd1);
        do_reset();
        wr(32'h8000_0000, 32'hBAD0_BAD0);
        chk("err_bad_write", {31'b0, addr_err}, 32'd1);
        rd("ram_untouched", 32'h0000_0000, 32'h1111_1111);
        do_reset();
        chk("err_cleared2", {31'b0, addr_err}, 32'd0);
`ifndef DMEM_CYCLE_COUNTER_EN
        rd("cycles_unmapped", CYC_A, 32'd0);
        chk("err_cycles", {31'b0, addr_err}, 32'd1);
        do_reset();
`endif

        // Reset mid-transfer
        for (int i = 0; i < 3; i++) wr(TX_A, 32'h41 + 32'(i));
        chk("queued_valid", {31'b0, con_valid}, 32'd1);
        do_reset();
        chk("midrst_valid", {31'b0, con_valid}, 32'd0);
        chk("midrst_data", {24'b0, con_data}, 32'd0);
        rd("midrst_status", ST_A, 32'h0000_0001);
        rd("midrst_ram", 32'h0000_0010, 32'h1234_5678);

`ifdef DMEM_CYCLE_COUNTER_EN
        do_reset();
        repeat (5) tick();
        data_addr = CYC_A;
        mem_read  = 1'b1;
        #1;
        chk("cycles_5", proc_rdata, 32'd5);
        mem_read = 1'b0;
        tick();
        wr(CYC_A, 32'hFFFF_FFFF);
        tick();
        data_addr = CYC_A;
        mem_read  = 1'b1;
        #1;
        chk("cycles_after_clr", proc_rdata, 32'd1);
        force dut.r_cycles = 32'hFFFF_FFFF;
        #1;
        chk("cycles_forced", proc_rdata, 32'hFFFF_FFFF);
        release dut.r_cycles;
        tick();
        chk("cycles_wrap", proc_rdata, 32'd0);
        mem_read = 1'b0;
        chk("cycles_no_err", {31'b0, addr_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
